// File: rtl/tpu_result_writer.sv
// Result-capture stage between the systolic array result bus and the result SRAM.
// Deskews the diagonal wavefront, optionally reverses lanes, and writes a programmed row window.
module tpu_result_writer #(
  parameter int MATRIX_SIZE    = 128,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int ADDRESSSIZE    = 10,
  parameter int LAT_BW         = 8,
  parameter bit LANE_REVERSE   = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [ADDRESSSIZE-1:0]                num_rows,
  input  logic [LAT_BW-1:0]                     fill_latency,
  input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] result_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow,
  output logic                                  wr_en,
  output logic [ADDRESSSIZE-1:0]                wr_addr,
  output logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q, base_d;
  logic [ADDRESSSIZE-1:0] rows_q, rows_d;
  logic [ADDRESSSIZE-1:0] row_q, row_d;
  logic [LAT_BW-1:0]      lat_cnt_q, lat_cnt_d;
  logic                   busy_d, done_d, ovf_d, wr_en_d;
  logic [ADDRESSSIZE-1:0] addr_d, addr_inc;

  logic signed [PARTIAL_SUM_BW-1:0] d_lane [MATRIX_SIZE];

  // Deskew: lane i waits MATRIX_SIZE-i stages so the whole row lines up.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    localparam int DEPTH = MATRIX_SIZE - i;
    logic signed [PARTIAL_SUM_BW-1:0] skew_p [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < DEPTH; j++) skew_p[j] <= '0;
      end else begin
        skew_p[0] <= result_in[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
        for (int j = 1; j < DEPTH; j++) skew_p[j] <= skew_p[j-1];
      end
    end

    assign d_lane[i] = skew_p[DEPTH-1];
  end

  for (genvar o = 0; o < MATRIX_SIZE; o++) begin : g_out
    localparam int SRC = LANE_REVERSE ? (MATRIX_SIZE - 1 - o) : o;
    assign wr_data[o*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = d_lane[SRC];
  end

  assign addr_inc = wr_addr + ADDRESSSIZE'(1);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rows_d    = rows_q;
    row_d     = row_q;
    lat_cnt_d = lat_cnt_q;
    busy_d    = busy;
    done_d    = 1'b0;
    ovf_d     = overflow;
    wr_en_d   = 1'b0;
    addr_d    = wr_addr;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          base_d    = base_addr;
          rows_d    = num_rows;
          lat_cnt_d = fill_latency;
          row_d     = '0;
          ovf_d     = 1'b0;
          if (num_rows == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (fill_latency != '0) begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            busy_d  = 1'b1;
            wr_en_d = 1'b1;
            addr_d  = base_addr;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (lat_cnt_q <= LAT_BW'(1)) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
          addr_d  = base_q;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_BW'(1);
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (row_q == rows_q - ADDRESSSIZE'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // Any address below base after the first row means the window wrapped.
          row_d   = row_q + ADDRESSSIZE'(1);
          addr_d  = addr_inc;
          wr_en_d = 1'b1;
          if (addr_inc < base_q) ovf_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      rows_q    <= '0;
      row_q     <= '0;
      lat_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rows_q    <= rows_d;
      row_q     <= row_d;
      lat_cnt_q <= lat_cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      overflow  <= ovf_d;
      wr_en     <= wr_en_d;
      wr_addr   <= addr_d;
    end
  end

endmodule

// File: doc/tpu_result_writer.md
Name: tpu_result_writer

Overview:
- Parametrised result-capture stage that sits between the systolic array `result` bus and the result SRAM.
- Deskews the diagonal output wavefront internally and optionally reverses lane order.
- Writes a programmable number of rows to a programmable base address, replacing the fixed 7-bit-counter write path.
- Adds start/abort control, a busy indication, a done pulse and address-wrap detection.

Parameters:
- MATRIX_SIZE, 128, number of result lanes (array columns).
- PARTIAL_SUM_BW, 24, bits per lane.
- ADDRESSSIZE, 10, result SRAM address width.
- LAT_BW, 8, width of the fill_latency field.
- LANE_REVERSE, 1, 1 = wr_data lane i is deskewed lane MATRIX_SIZE-1-i; 0 = no reversal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a capture.
- abort  input  1  terminate the capture in progress.
- base_addr  input  ADDRESSSIZE  first write address; sampled on accepted start.
- num_rows  input  ADDRESSSIZE  rows to write; sampled on accepted start.
- fill_latency  input  LAT_BW  idle cycles between start and first write; sampled on accepted start.
- result_in  input  MATRIX_SIZE*PARTIAL_SUM_BW  skewed array output; lane i at bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
- busy  output  1  high in WAIT and WRITE.
- done  output  1  one-cycle pulse after the last write.
- overflow  output  1  sticky; address wrapped during the current capture.
- wr_en  output  1  result SRAM write enable.
- wr_addr  output  ADDRESSSIZE  result SRAM address.
- wr_data  output  MATRIX_SIZE*PARTIAL_SUM_BW  result SRAM write data.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, overflow, wr_en, wr_addr and all deskew registers go to 0.
  - Reset asserted mid-capture aborts immediately; no done pulse is generated.
- Deskew (free-running, not gated by FSM):
  - Lane i is delayed by MATRIX_SIZE-i register stages.
  - D_i(t) = result_in_i(t-(MATRIX_SIZE-i)): lane MATRIX_SIZE-1 is delayed 1 cycle, lane 0 is delayed MATRIX_SIZE cycles.
  - wr_data is D, lane-reversed when LANE_REVERSE=1. It is combinational from the deskew registers, with no extra stage.
- FSM states: IDLE, WAIT, WRITE, DONE.
  - IDLE:
    - start=1 and abort=0 at edge k accepts the request.
    - On acceptance, latch base_addr, num_rows and fill_latency; clear overflow; clear the row counter.
    - Next state: DONE if num_rows==0; else WAIT if fill_latency>0; else WRITE.
    - start is ignored outside IDLE.
  - WAIT:
    - Latency counter runs fill_latency cycles, then the FSM moves to WRITE.
    - First wr_en is in cycle k+1+fill_latency.
  - WRITE:
    - wr_en=1 for exactly num_rows consecutive cycles.
    - wr_addr = (base_addr + row) mod 2^ADDRESSSIZE, row = 0..num_rows-1.
    - After the last row the FSM moves to DONE.
  - DONE:
    - done=1 for one cycle, busy=0, then IDLE.
    - start in DONE is ignored.
- abort:
  - In WAIT or WRITE: next state IDLE, and wr_en=0 from the next cycle.
  - abort produces no done pulse; overflow keeps its value.
  - abort in IDLE or DONE has no effect beyond blocking a simultaneous start.
  - start and abort together in IDLE: abort wins and start is not accepted.
- overflow:
  - Set in the cycle a write occurs whose row>0 and wr_addr < base_addr, i.e. the address wrapped.
  - Holds until the next accepted start.
- Outputs are registered except wr_data. wr_addr holds its last value when wr_en=0.
- Widths: the row and latency counters are ADDRESSSIZE and LAT_BW bits. num_rows = 2^ADDRESSSIZE-1 is the maximum supported row count.

Test Plan:
- Bench configuration for all scenarios: MATRIX_SIZE=4, PARTIAL_SUM_BW=8, ADDRESSSIZE=4.
- Basic capture: start with base=2, rows=3, latency=0.
  - Expected: wr_en in cycles k+1..k+3; wr_addr 2,3,4; done at k+4; busy high k+1..k+3.
- Deskew and reverse: drive lane i = 0x10*(i+1)+t, so lane i carries value 0x10*(i+1)+t at cycle t; LANE_REVERSE=1.
  - Expected at cycle T: wr_data lane 3 = 0x10+(T-4) and lane 0 = 0x40+(T-1), from D_0 and D_3.
  - Repeat with LANE_REVERSE=0 and check the unreversed lane order.
- Latency and wrap: base=14, rows=4, latency=5.
  - Expected: first wr_en at k+6; addresses 14,15,0,1; overflow rises with the write to address 0 and stays high until the next start.
- Abort: abort during the 2nd write of a rows=6 capture.
  - Expected: wr_en low the next cycle, no done, busy low, FSM in IDLE.
  - A new start 1 cycle later is accepted.
- Edge cases:
  - rows=0: done at k+1 and no wr_en.
  - start+abort together in IDLE: nothing happens.
  - start while busy: ignored.
  - rst pulse mid-WRITE: all outputs 0 asynchronously, within the same cycle.
